// File: rtl/spi_slave_regbank_pkg.sv
// Shared definitions for the SPI register-bank slave: header field layout and FSM states.
package spi_pkg;

    typedef enum logic [1:0] {
        ST_HDR  = 2'd0,
        ST_DATA = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Header bits arrive LSB-first: WR, device address, BURST, register address.
    localparam int WR_POS  = 0;
    localparam int DEV_LSB = 1;

    function automatic int hdr_len(input int dev_w, input int addr_w);
        return dev_w + addr_w + 2;
    endfunction

    function automatic int burst_pos(input int dev_w);
        return dev_w + 1;
    endfunction

    function automatic int raddr_lsb(input int dev_w);
        return dev_w + 2;
    endfunction

endpackage

// File: rtl/spi_slave_regbank_if.sv
// Serial bus pins seen by the slave; the master owns cs/mosi, the slave owns miso/miso_oe.
interface spi_slave_regbank_if;
    // cs is an active-high frame select sampled on posedge sclk; miso is only
    // meaningful while miso_oe is high and is forced to 0 otherwise.
    logic cs;
    logic mosi;
    logic miso;
    logic miso_oe;

    modport master (
        output cs,
        output mosi,
        input  miso,
        input  miso_oe
    );

    modport slave (
        input  cs,
        input  mosi,
        output miso,
        output miso_oe
    );
endinterface

// File: rtl/spi_slave_regbank_shift_word.sv
// Parallel-load MSB-first shift register; serial data enters at the LSB.
module spi_shift_word #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         shift,
    input  logic         sin,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (shift) begin
            q <= {q[W-2:0], sin};
        end
    end

endmodule

// File: rtl/spi_slave_regbank.sv
// SPI slave with a parametrised register bank: header decode, full-duplex data words, burst auto-increment.
module spi_slave_regbank
    import spi_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 3,
    parameter int DEV_ADDR_W = 3,
    parameter logic [DATA_W*(2**ADDR_W)-1:0] RESET_VALUES =
        {8'h39, 8'h46, 8'h75, 8'h36, 8'h35, 8'h35, 8'h52, 8'h12},
    parameter logic [(2**ADDR_W)-1:0] RO_MASK = '0
) (
    input  logic                          sclk,
    input  logic                          rst,
    spi_slave_regbank_if.slave            bus,
    input  logic [DEV_ADDR_W-1:0]         addr,
    output logic                          wr_pulse,
    output logic [ADDR_W-1:0]             wr_addr,
    output logic [DATA_W-1:0]             wr_data,
    output logic [DATA_W*(2**ADDR_W)-1:0] regs_flat,
    output logic [1:0]                    dbg_state
);

    localparam int NREG  = 2**ADDR_W;
    localparam int H     = hdr_len(DEV_ADDR_W, ADDR_W);
    localparam int CNT_W = $clog2(H);
    localparam int BIT_W = $clog2(DATA_W);
    localparam int BPOS  = burst_pos(DEV_ADDR_W);
    localparam int RLSB  = raddr_lsb(DEV_ADDR_W);

    localparam logic [1:0] HDR  = ST_HDR;
    localparam logic [1:0] DATA = ST_DATA;
    localparam logic [1:0] DONE = ST_DONE;

    logic [1:0]        state;
    logic [H-2:0]      hdr_sr;
    logic [CNT_W-1:0]  hdr_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic              wr_q;
    logic              burst_q;
    logic [ADDR_W-1:0] cur_addr;
    logic              oe_q;
    logic [DATA_W-1:0] bank [NREG];

    logic [H-1:0]      hdr_full;
    logic              hdr_wr;
    logic              hdr_burst;
    logic              hdr_match;
    logic [ADDR_W-1:0] hdr_raddr;
    logic              hdr_last;
    logic              word_last;
    logic [ADDR_W-1:0] next_addr;
    logic              sr_load;
    logic              sr_shift;
    logic [DATA_W-1:0] sr_load_val;
    logic [DATA_W-1:0] sr_q;
    logic [DATA_W-1:0] captured;

    // The header is complete on the edge that samples its last bit, so decode
    // from the live mosi bit concatenated with the bits already collected.
    assign hdr_full  = {bus.mosi, hdr_sr};
    assign hdr_wr    = hdr_full[WR_POS];
    assign hdr_match = (hdr_full[DEV_LSB +: DEV_ADDR_W] == addr);
    assign hdr_burst = hdr_full[BPOS];
    assign hdr_raddr = hdr_full[RLSB +: ADDR_W];

    assign hdr_last  = (state == HDR)  && (hdr_cnt == CNT_W'(H - 1));
    assign word_last = (state == DATA) && (bit_cnt == BIT_W'(DATA_W - 1));
    assign next_addr = cur_addr + ADDR_W'(1);
    assign captured  = {sr_q[DATA_W-2:0], bus.mosi};

    assign sr_load     = bus.cs && ((hdr_last && hdr_match) || (word_last && burst_q));
    assign sr_load_val = hdr_last ? bank[hdr_raddr] : bank[next_addr];
    assign sr_shift    = bus.cs && (state == DATA) && !word_last;

    spi_shift_word #(.W(DATA_W)) u_shift (
        .clk      (sclk),
        .rst      (rst),
        .load     (sr_load),
        .load_val (sr_load_val),
        .shift    (sr_shift),
        .sin      (bus.mosi),
        .q        (sr_q)
    );

    assign bus.miso    = oe_q & sr_q[DATA_W-1];
    assign bus.miso_oe = oe_q;
    assign dbg_state   = state;

    always_comb begin
        regs_flat = '0;
        for (int i = 0; i < NREG; i++) begin
            regs_flat[i*DATA_W +: DATA_W] = bank[i];
        end
    end

    always_ff @(posedge sclk or negedge rst) begin
        if (!rst) begin
            state    <= HDR;
            hdr_sr   <= '0;
            hdr_cnt  <= '0;
            bit_cnt  <= '0;
            wr_q     <= 1'b0;
            burst_q  <= 1'b0;
            cur_addr <= '0;
            oe_q     <= 1'b0;
            wr_pulse <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            for (int i = 0; i < NREG; i++) begin
                bank[i] <= RESET_VALUES[i*DATA_W +: DATA_W];
            end
        end else begin
            wr_pulse <= 1'b0;
            if (!bus.cs) begin
                state   <= HDR;
                hdr_cnt <= '0;
                bit_cnt <= '0;
                oe_q    <= 1'b0;
            end else begin
                case (state)
                    HDR: begin
                        hdr_sr <= hdr_full[H-1:1];
                        if (hdr_last) begin
                            hdr_cnt  <= '0;
                            bit_cnt  <= '0;
                            wr_q     <= hdr_wr;
                            burst_q  <= hdr_burst;
                            cur_addr <= hdr_raddr;
                            if (hdr_match) begin
                                state <= DATA;
                                oe_q  <= 1'b1;
                            end else begin
                                state <= DONE;
                            end
                        end else begin
                            hdr_cnt <= hdr_cnt + CNT_W'(1);
                        end
                    end
                    DATA: begin
                        if (word_last) begin
                            bit_cnt <= '0;
                            if (wr_q && !RO_MASK[cur_addr]) begin
                                bank[cur_addr] <= captured;
                                wr_pulse       <= 1'b1;
                                wr_addr        <= cur_addr;
                                wr_data        <= captured;
                            end
                            if (burst_q) begin
                                cur_addr <= next_addr;
                            end else begin
                                state <= DONE;
                                oe_q  <= 1'b0;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end
                    default: begin
                        // DONE: wait for cs to fall, ignoring mosi.
                    end
                endcase
            end
        end
    end

endmodule
